// File: rtl/periph_bridge.sv
// periph_bridge: bridges single core data requests into a window of
// memory-mapped peripheral slots.
//
// Ports
//   clock, reset          : sole clock; synchronous active-high reset
//   d_addr/d_wdata/
//   d_store_type/d_valid  : core request (store type nonzero = write)
//   d_rdata/d_ready       : core response, d_ready pulses one cycle
//   s_req/s_sel/s_addr/
//   s_wdata/s_store_type  : request to the selected slave, held while waiting
//   s_ack/s_rdata         : per-slot acknowledge and read data (slot i at [64i+63:64i])
//   bus_err_clear         : clears the sticky error flag
//   bus_err_irq           : sticky error flag (decode miss or slave timeout)

package periph_bridge_pkg;
  typedef logic [2:0] mem_store_type_t;
endpackage

module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
  parameter int unsigned OFFSET_W        = 12,
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [63:0]               d_addr,
  input  logic [63:0]               d_wdata,
  input  mem_store_type_t           d_store_type,
  input  logic                      d_valid,
  output logic [63:0]               d_rdata,
  output logic                      d_ready,
  output logic                      s_req,
  output logic [NUM_SLOTS-1:0]      s_sel,
  output logic [OFFSET_W-1:0]       s_addr,
  output logic [63:0]               s_wdata,
  output mem_store_type_t           s_store_type,
  input  logic [NUM_SLOTS-1:0]      s_ack,
  input  logic [NUM_SLOTS*64-1:0]   s_rdata,
  input  logic                      bus_err_clear,
  output logic                      bus_err_irq
);

  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [OFFSET_W-1:0]  off_q, off_d;
  logic [63:0]          wdata_q, wdata_d;
  mem_store_type_t      st_q, st_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 s_req_q, s_req_d;
  logic [NUM_SLOTS-1:0] s_sel_q, s_sel_d;
  logic                 d_ready_q, d_ready_d;
  logic [63:0]          d_rdata_q, d_rdata_d;
  logic                 err_q, err_d;

  logic [63:0]          diff_s;
  logic                 hit_s;
  logic [IDX_W-1:0]     idx_s;
  logic                 ack_s;
  logic [63:0]          slot_rdata_s;
  logic                 set_err_s;

  function automatic logic [NUM_SLOTS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_SLOTS-1:0] v;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      v[k] = (32'(i) == k);
    end
    return v;
  endfunction

  // Address decode against the peripheral window.
  always_comb begin
    diff_s = d_addr - PERIPHERAL_BASE;
    hit_s  = (d_addr >= PERIPHERAL_BASE) && ((diff_s >> OFFSET_W) < 64'(NUM_SLOTS));
    idx_s  = IDX_W'(diff_s >> OFFSET_W);
  end

  // Only the acknowledge of the selected slot counts; strays are ignored.
  always_comb begin
    ack_s        = s_ack[idx_q];
    slot_rdata_s = s_rdata[32'(idx_q) * 32'd64 +: 64];
  end

  // Next-state and next-output logic; outputs are registered so the values
  // loaded here appear in the cycle belonging to the next state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    st_d      = st_q;
    cnt_d     = cnt_q;
    s_req_d   = 1'b0;
    s_sel_d   = '0;
    d_ready_d = 1'b0;
    d_rdata_d = d_rdata_q;
    set_err_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_valid) begin
          if (hit_s) begin
            idx_d   = idx_s;
            off_d   = diff_s[OFFSET_W-1:0];
            wdata_d = d_wdata;
            st_d    = d_store_type;
            cnt_d   = '0;
            s_req_d = 1'b1;
            s_sel_d = onehot(idx_s);
            state_d = ST_WAIT;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = 64'hFFFF_FFFF_FFFF_FFFF;
            set_err_s = 1'b1;
            state_d   = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (ack_s) begin
          d_ready_d = 1'b1;
          d_rdata_d = (st_q != '0) ? 64'd0 : slot_rdata_s;
          state_d   = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          d_ready_d = 1'b1;
          d_rdata_d = 64'hFFFF_FFFF_FFFF_FFFF;
          set_err_s = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          s_req_d = 1'b1;
          s_sel_d = onehot(idx_q);
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Setting the flag takes priority over a clear in the same cycle.
    err_d = set_err_s | (err_q & ~bus_err_clear);
  end

  // State, latches and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      off_q     <= '0;
      wdata_q   <= 64'd0;
      st_q      <= '0;
      cnt_q     <= '0;
      s_req_q   <= 1'b0;
      s_sel_q   <= '0;
      d_ready_q <= 1'b0;
      d_rdata_q <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      s_req_q   <= s_req_d;
      s_sel_q   <= s_sel_d;
      d_ready_q <= d_ready_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  assign s_req        = s_req_q;
  assign s_sel        = s_sel_q;
  assign s_addr       = off_q;
  assign s_wdata      = wdata_q;
  assign s_store_type = st_q;
  assign d_ready      = d_ready_q;
  assign d_rdata      = d_rdata_q;
  assign bus_err_irq  = err_q;

endmodule

// File: tb/tb_periph_bridge.sv
// Scoreboard bench for periph_bridge: a driver issues requests and pushes
// the expected response computed from address-window arithmetic; a monitor
// pops and compares on every d_ready pulse and watches the slave side.
module tb_periph_bridge;
  import periph_bridge_pkg::*;

  localparam logic [63:0] BASE = 64'h2000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clock = 1'b0;
  logic             reset;
  logic [63:0]      d_addr, d_wdata, d_rdata, s_wdata;
  mem_store_type_t  d_store_type, s_store_type;
  logic             d_valid, d_ready, s_req, bus_err_clear, bus_err_irq;
  logic [3:0]       s_sel, s_ack;
  logic [11:0]      s_addr;
  logic [255:0]     s_rdata;

  periph_bridge dut (
    .clock(clock), .reset(reset),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_store_type(d_store_type), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .s_req(s_req), .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_store_type(s_store_type),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .bus_err_clear(bus_err_clear), .bus_err_irq(bus_err_irq)
  );

  always #5 clock = ~clock;

  typedef struct { logic [63:0] data; logic err; } exp_t;
  exp_t exp_q[$];

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic [63:0] slot_data [4];
  int          cur_slot = 0;
  logic [3:0]  cur_sel = 4'd0;
  logic [11:0] cur_addr = 12'd0;
  logic [63:0] cur_wdata = 64'd0;
  logic [2:0]  cur_st = 3'd0;
  int          ack_delay = -1;
  logic [3:0]  stray_mask = 4'd0;
  int          sreq_cycles = 0;
  logic        model_err = 1'b0;
  logic [63:0] edges [6] = '{BASE, BASE + 64'd16383, BASE + 64'd16384, BASE - 64'd1, 64'd0, ONES};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: acks the expected slot after ack_delay waiting cycles.
  initial begin
    s_ack = 4'd0;
    for (int i = 0; i < 4; i++) slot_data[i] = 64'd0;
    forever begin
      @(negedge clock);
      s_ack = stray_mask & ~(4'b0001 << cur_slot);
      if (s_req) begin
        if (ack_delay >= 0 && sreq_cycles == ack_delay) s_ack[cur_slot] = 1'b1;
        sreq_cycles++;
      end
      for (int i = 0; i < 4; i++) s_rdata[64*i +: 64] = slot_data[i];
    end
  end

  // Monitor: response scoreboard, d_rdata hold, slave-side request stability.
  initial begin
    logic [63:0] last;
    logic        rst_pend;
    exp_t        e;
    last = 64'd0;
    rst_pend = 1'b0;
    forever begin
      @(negedge clock);
      if (rst_pend) last = 64'd0;
      rst_pend = reset;
      if (d_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_d_ready", {63'd0, d_ready}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", d_rdata, e.data);
          chk("resp_err_irq", {63'd0, bus_err_irq}, {63'd0, e.err});
          last = e.data;
        end
      end else begin
        chk("rdata_hold", d_rdata, last);
      end
      if (s_req) begin
        chk("s_sel", {60'd0, s_sel}, {60'd0, cur_sel});
        chk("s_addr", {52'd0, s_addr}, {52'd0, cur_addr});
        chk("s_wdata", s_wdata, cur_wdata);
        chk("s_store_type", {61'd0, s_store_type}, {61'd0, cur_st});
      end else begin
        chk("s_sel_idle", {60'd0, s_sel}, 64'd0);
      end
    end
  end

  // Issue one request, push its expected response, wait for d_ready and
  // check latency and the number of s_req cycles.
  task automatic do_req(input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] st,
                        input int delay, input logic clr, input logic [3:0] stray, output int ready_cyc);
    logic        hit;
    logic [63:0] rel, data;
    logic        err;
    int          lat, nsreq, issue, got;
    rel = addr - BASE;
    hit = (addr >= BASE) && (rel / 64'd4096 < 64'd4);
    for (int i = 0; i < 4; i++) slot_data[i] = {$urandom, $urandom};
    if (!hit) begin
      data = ONES; err = 1'b1; lat = 1; nsreq = 0;
    end else begin
      cur_slot  = int'(rel / 64'd4096);
      cur_sel   = 4'b0001 << cur_slot;
      cur_addr  = 12'(rel % 64'd4096);
      cur_wdata = wdata;
      cur_st    = st;
      if (delay < 0 || delay > 255) begin
        data = ONES; err = 1'b1; lat = 257; nsreq = 256;
      end else begin
        data = (st != 3'd0) ? 64'd0 : slot_data[cur_slot];
        err = 1'b0; lat = delay + 2; nsreq = delay + 1;
      end
    end
    model_err = err | (model_err & ~clr);
    exp_q.push_back('{data, model_err});
    ack_delay = hit ? delay : -1;
    stray_mask = stray;
    sreq_cycles = 0;
    issue = cyc;
    d_addr = addr; d_wdata = wdata; d_store_type = st; d_valid = 1'b1; bus_err_clear = clr;
    @(posedge clock); #1;
    d_valid = 1'b0; bus_err_clear = 1'b0;
    d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom}; d_store_type = 3'($urandom);
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      @(negedge clock);
      if (d_ready) got = 1;
    end
    chk("d_ready_seen", 64'(got), 64'd1);
    ready_cyc = cyc;
    chk("latency", 64'(cyc - issue), 64'(lat));
    chk("s_req_cycles", 64'(sreq_cycles), 64'(nsreq));
    ack_delay = -1;
    stray_mask = 4'd0;
    @(posedge clock); #1;
  endtask

  task automatic pulse_clear();
    bus_err_clear = 1'b1;
    model_err = 1'b0;
    @(posedge clock); #1;
    bus_err_clear = 1'b0;
    @(negedge clock);
    chk("err_cleared", {63'd0, bus_err_irq}, 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    int r0, r1, n_ready;
    reset = 1'b1; d_addr = 64'd0; d_wdata = 64'd0; d_store_type = 3'd0;
    d_valid = 1'b0; bus_err_clear = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_s_req", {63'd0, s_req}, 64'd0);
    chk("rst_d_ready", {63'd0, d_ready}, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_irq", {63'd0, bus_err_irq}, 64'd0);
    @(posedge clock); #1;

    // Read hit, slot 1 acks after two waiting cycles.
    do_req(64'h2000_1010, 64'd0, 3'd0, 2, 1'b0, 4'd0, r0);
    // Write hit, slot 3 acks immediately.
    do_req(64'h2000_3008, 64'hAB, 3'd3, 0, 1'b0, 4'd0, r0);
    // Miss just past the window, then clear the flag.
    do_req(64'h2000_4000, 64'd0, 3'd0, 0, 1'b0, 4'd0, r0);
    pulse_clear();
    // Timeout on slot 0, then an ack on the final waiting cycle.
    do_req(64'h2000_0000, 64'd0, 3'd0, -1, 1'b0, 4'b1110, r0);
    pulse_clear();
    do_req(64'h2000_0008, 64'd0, 3'd0, 255, 1'b0, 4'd0, r0);
    // Back-to-back reads to slots 0 and 2 with a stray ack on slot 1.
    do_req(64'h2000_0040, 64'd0, 3'd0, 0, 1'b0, 4'b0010, r0);
    do_req(64'h2000_2040, 64'd0, 3'd0, 0, 1'b0, 4'b0010, r1);
    chk("b2b_gap", 64'(r1 - r0), 64'd3);
    // Set and clear in the same cycle: set wins.
    do_req(BASE - 64'd1, 64'd0, 3'd0, 0, 1'b1, 4'd0, r0);

    for (int n = 0; n < 60; n++) begin
      int          cat, dl;
      logic [63:0] a;
      cat = $urandom_range(0, 5);
      case (cat)
        0, 1, 2: a = BASE + 64'($urandom_range(0, 3)) * 64'd4096 + 64'($urandom_range(0, 4095));
        3:       a = BASE - 64'd1 - 64'($urandom_range(0, 100000));
        4:       a = BASE + 64'd16384 + 64'($urandom);
        default: a = edges[$urandom_range(0, 5)];
      endcase
      dl = $urandom_range(0, 19);
      if (dl == 19) dl = -1;
      else if (dl == 18) dl = 255;
      else dl = dl % 5;
      do_req(a, {$urandom, $urandom}, 3'($urandom_range(0, 7)), dl,
             ($urandom_range(0, 7) == 0), 4'($urandom), r0);
    end

    // Reset in the middle of a wait: set up nonzero response and error first.
    do_req(64'h0000_1000, 64'd0, 3'd0, 0, 1'b0, 4'd0, r0);
    cur_slot = 2; cur_sel = 4'b0100; cur_addr = 12'h0F8; cur_wdata = 64'h55; cur_st = 3'd2;
    ack_delay = -1;
    d_addr = 64'h2000_20F8; d_wdata = 64'h55; d_store_type = 3'd2; d_valid = 1'b1;
    @(posedge clock); #1 d_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("wait_s_req", {63'd0, s_req}, 64'd1);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    model_err = 1'b0;
    @(negedge clock);
    chk("rstw_s_req", {63'd0, s_req}, 64'd0);
    chk("rstw_s_sel", {60'd0, s_sel}, 64'd0);
    chk("rstw_d_rdata", d_rdata, 64'd0);
    chk("rstw_irq", {63'd0, bus_err_irq}, 64'd0);
    chk("rstw_s_wdata", s_wdata, 64'd0);
    n_ready = 0;
    repeat (10) begin
      if (d_ready) n_ready++;
      @(negedge clock);
    end
    chk("rstw_no_ready", 64'(n_ready), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/periph_bridge.md
PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 SHALL have parameter PERIPHERAL_BASE, default 64'h2000_0000: base address of peripheral window.
REQ-002 SHALL have parameter OFFSET_W, default 12: slot offset width; slot size 2**OFFSET_W bytes.
REQ-003 SHALL have parameter NUM_SLOTS, default 4: number of peripheral slots.
REQ-004 SHALL have parameter TIMEOUT, default 255: max WAIT cycles before forced error response.
REQ-005 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports d_addr input 64, d_wdata input 64, d_store_type input mem_store_type_t, d_valid input 1: core request.
REQ-008 SHALL have ports d_rdata output 64, d_ready output 1: core response.
REQ-009 SHALL have ports s_req output 1, s_sel output NUM_SLOTS (one-hot), s_addr output OFFSET_W, s_wdata output 64, s_store_type output mem_store_type_t: slave request.
REQ-010 SHALL have ports s_ack input NUM_SLOTS, s_rdata input NUM_SLOTS*64 (slot i at bits [64i+63:64i]): slave response.
REQ-011 SHALL have ports bus_err_clear input 1 (clear pulse), bus_err_irq output 1 (sticky error, drives one interrupt_sources bit).

Function
REQ-012 SHALL treat a request as a write when d_store_type is nonzero, else a read.
REQ-013 SHALL decode hit when d_addr >= PERIPHERAL_BASE and idx = (d_addr - PERIPHERAL_BASE) >> OFFSET_W is < NUM_SLOTS; otherwise miss.
REQ-014 SHALL implement states IDLE, WAIT, RESP.
REQ-015 IDLE: on d_valid with hit, SHALL latch idx, offset (low OFFSET_W bits of d_addr - PERIPHERAL_BASE), d_wdata, d_store_type and go WAIT; timeout counter cleared to 0.
REQ-016 IDLE: on d_valid with miss, SHALL go RESP with response data 64'hFFFF_FFFF_FFFF_FFFF and set error flag.
REQ-017 WAIT: SHALL hold s_req=1, s_sel=one-hot(idx), s_addr/s_wdata/s_store_type from latches, stable every WAIT cycle.
REQ-018 WAIT: on s_ack[idx]=1 SHALL latch s_rdata slot idx (writes: latch 0) and go RESP; s_ack bits of unselected slots SHALL be ignored.
REQ-019 WAIT: counter increments each cycle without ack; when counter == TIMEOUT without ack SHALL go RESP with data all-ones and set error flag.
REQ-020 ack and timeout in same cycle: ack SHALL win (no error).
REQ-021 RESP: SHALL assert d_ready=1 and drive d_rdata for exactly one cycle, then IDLE unconditionally.
REQ-022 Outside RESP, d_ready SHALL be 0; d_rdata SHALL hold last response value.
REQ-023 Outside WAIT, s_req and s_sel SHALL be 0.
REQ-024 Min latency: d_valid sampled cycle N, s_req cycle N+1, ack at N+1 gives d_ready at N+2; miss gives d_ready at N+1.
REQ-025 IDLE after RESP SHALL accept a new d_valid in the very next cycle (back-to-back accesses).
REQ-026 d_valid dropping during WAIT (pipeline flush) SHALL NOT abort: slave transaction completes, d_ready still pulses.
REQ-027 bus_err_irq SHALL equal sticky error flag; bus_err_clear clears it; set and clear in same cycle: set wins.

Reset
REQ-028 reset SHALL force IDLE, counter 0, s_req 0, s_sel 0, d_ready 0, d_rdata 0, bus_err_irq 0, latches 0.
REQ-029 reset mid-WAIT SHALL drop s_req next cycle and produce no d_ready.

Verification
REQ-030 Read hit: d_addr=64'h2000_1010, read, slot1 acks 2 cycles later with 64'h1234 -> s_sel=4'b0010, s_addr=12'h010, d_ready one cycle with d_rdata=64'h1234.
REQ-031 Write hit: d_addr=64'h2000_3008, d_wdata=64'hAB, store type nonzero, slot3 acks immediately -> s_wdata=64'hAB, d_ready at N+2, bus_err_irq=0.
REQ-032 Miss: d_addr=64'h2000_4000 -> no s_req, d_ready at N+1, d_rdata all-ones, bus_err_irq=1; bus_err_clear pulse -> 0.
REQ-033 Timeout: slot0 never acks, TIMEOUT=255 -> s_req high 256 cycles, then d_ready with all-ones, bus_err_irq=1; repeat with ack on final cycle -> normal data, no error.
REQ-034 Back-to-back: two reads to slots 0 and 2 with immediate acks -> two d_ready pulses 3 cycles apart, correct data each; stray s_ack[1] ignored.
REQ-035 Reset in WAIT: assert reset while s_req=1 -> next cycle all outputs at reset values, no d_ready.
